// File: rtl/spi_arb.sv
// Two-requester round-robin arbiter in front of a single SPI master.
// Grants, launches, waits for completion (or watchdog timeout), then enforces an inter-transaction gap.
module spi_arb #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  ss0,
    input  logic [2:0]  ss1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [7:0]  rd_data,
    output logic        wrt_SPI,
    output logic [15:0] SPI_data,
    output logic [2:0]  ss,
    input  logic        SPI_done,
    input  logic [7:0]  EEP_data
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

    state_t          state, state_d;
    logic            last_gnt;
    logic            pick1;
    logic            any_req;
    logic            timeout;
    logic            finish;
    logic [WW-1:0]   wd_cnt;
    logic [GW-1:0]   gap_cnt;

    always_comb begin
        pick1   = req1 && (!req0 || !last_gnt);
        any_req = req0 || req1;
        // Fire on the edge that would take the watchdog to TIMEOUT, so done/err land TIMEOUT cycles after BUSY entry.
        timeout = (state == BUSY) && !SPI_done && (wd_cnt == WD_LAST);
        finish  = (state == BUSY) && (SPI_done || timeout);
        state_d = state;
        case (state)
            IDLE:    if (any_req) state_d = LAUNCH;
            LAUNCH:  state_d = BUSY;
            BUSY:    if (finish) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
            ss       <= '0;
            SPI_data <= '0;
            rd_data  <= '0;
            wrt_SPI  <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err      <= 1'b0;
            wd_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            wrt_SPI <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt0     <= !pick1;
                        gnt1     <= pick1;
                        last_gnt <= pick1;
                        ss       <= pick1 ? ss1 : ss0;
                        SPI_data <= pick1 ? data1 : data0;
                    end
                end
                LAUNCH: begin
                    wrt_SPI <= 1'b1;
                    wd_cnt  <= '0;
                end
                BUSY: begin
                    if (finish) begin
                        done0   <= !last_gnt;
                        done1   <= last_gnt;
                        err     <= timeout;
                        ss      <= '0;
                        gap_cnt <= '0;
                        if (SPI_done) rd_data <= EEP_data;
                    end else if (wd_cnt != WD_MAX) begin
                        wd_cnt <= wd_cnt + WW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
